// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the chunked sequential wide adder: FSM states,
// default widths and helpers that size the chunk counter.
package wide_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_W = 16;
    localparam int DEF_N = 4;

    // Number of N-bit chunks in a W-bit operand.
    function automatic int chunk_count(input int w, input int n);
        return w / n;
    endfunction

    // Width of the chunk index; a single chunk still needs one bit.
    function automatic int idx_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/wide_add_seq_add.sv
// N-bit ripple-carry adder; s[N] is the carry out of the top bit.
module wide_add_seq_add #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N:0]   s
);

    logic [N:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign s[N] = c[N];

endmodule

// File: rtl/wide_add_seq.sv
// Sequential W-bit adder: accepts a, b, ci, then adds one N-bit chunk per
// cycle through a single shared adder and presents {co, sum} until taken.
//
// Handshake: an operand set transfers on a rising edge where in_valid and
// in_ready are both 1; a result transfers on an edge where out_valid and
// out_ready are both 1. in_ready and out_valid are decoded from the state
// register only, so neither depends combinationally on any input.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N   // W must be a multiple of N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         co,
    output state_t       dbg_state
);

    localparam int K  = chunk_count(W, N);
    localparam int IW = idx_width(K);

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  sum_q;
    logic          co_q;

    logic          accept;
    logic          step;
    logic          idx_last;
    logic [N-1:0]  a_chunk;
    logic [N-1:0]  b_chunk;
    logic [N:0]    chunk_s;

    assign accept   = (state_q == ST_IDLE) && in_valid;
    assign step     = (state_q == ST_RUN);
    assign idx_last = (idx_q == IW'(K - 1));

    // Chunk select: route the idx-th slice of the captured operands into the adder.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int g = 0; g < K; g++) begin
            if (idx_q == IW'(g)) begin
                a_chunk = a_q[g*N +: N];
                b_chunk = b_q[g*N +: N];
            end
        end
    end

    wide_add_seq_add #(
        .N (N)
    ) u_add (
        .a  (a_chunk),
        .b  (b_chunk),
        .ci (carry_q),
        .s  (chunk_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (idx_last)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Operands are written only on acceptance, so they stay frozen through RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= ci;
                idx_q   <= '0;
            end
            if (step) begin
                carry_q <= chunk_s[N];
                idx_q   <= idx_q + 1'b1;
                for (int g = 0; g < K; g++) begin
                    if (idx_q == IW'(g)) begin
                        sum_q[g*N +: N] <= chunk_s[N-1:0];
                    end
                end
                if (idx_last) begin
                    co_q <= chunk_s[N];
                end
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign co        = co_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and back-to-back checks of wide_add_seq at W=16/N=4, plus a
// single-chunk W=8/N=8 instance.
module tb_wide_add_seq;
    import wide_add_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        co;
    state_t      dbg_state;

    logic        k1_in_valid;
    logic        k1_in_ready;
    logic [7:0]  k1_a;
    logic [7:0]  k1_b;
    logic        k1_ci;
    logic        k1_out_valid;
    logic        k1_out_ready;
    logic [7:0]  k1_sum;
    logic        k1_co;
    state_t      k1_dbg_state;

    logic [16:0] exp_q[$];
    logic [16:0] last_exp;
    int          checks;
    int          errors;

    wide_add_seq #(.W(16), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .dbg_state (dbg_state)
    );

    wide_add_seq #(.W(8), .N(8)) dut_k1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (k1_in_valid),
        .in_ready  (k1_in_ready),
        .a         (k1_a),
        .b         (k1_b),
        .ci        (k1_ci),
        .out_valid (k1_out_valid),
        .out_ready (k1_out_ready),
        .sum       (k1_sum),
        .co        (k1_co),
        .dbg_state (k1_dbg_state)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y,
                                            input logic c);
        return 17'(x) + 17'(y) + 17'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand set while idle; the following edge accepts it.
    task automatic accept(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv);
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        ci       = cv;
        in_valid = 1'b1;
        exp_q.push_back(ref_sum(av, bv, cv));
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid, then score the result.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check({tag, " sum"}, 32'(sum), 32'(last_exp[15:0]));
            check({tag, " co"}, 32'(co), 32'(last_exp[16]));
        end else begin
            check({tag, " scoreboard empty"}, 32'(exp_q.size()), 32'd1);
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
        check({tag, " sum held after take"}, 32'(sum), 32'(last_exp[15:0]));
        check({tag, " co held after take"}, 32'(co), 32'(last_exp[16]));
    endtask

    initial begin
        int lat;
        int accepted;
        int results;
        int last_acc;
        int cyc;
        logic [16:0] e;

        checks       = 0;
        errors       = 0;
        last_exp     = '0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        a            = '0;
        b            = '0;
        ci           = 1'b0;
        k1_in_valid  = 1'b0;
        k1_out_ready = 1'b0;
        k1_a         = '0;
        k1_b         = '0;
        k1_ci        = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset sum", 32'(sum), 32'd0);
        check("reset co", 32'(co), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();

        // Wrap-around shows only as carry out
        accept("wrap", 16'hFFFF, 16'h0001, 1'b0);
        wait_result("wrap", 4);
        check("wrap sum const", 32'(sum), 32'h0000);
        check("wrap co const", 32'(co), 32'd1);
        handshake("wrap");

        // Carry in to chunk 0
        accept("cin", 16'h1234, 16'h4321, 1'b1);
        wait_result("cin", 4);
        check("cin sum const", 32'(sum), 32'h5556);
        handshake("cin");

        // Backpressure with ignored in_valid pulses
        accept("bp", 16'h8F0F, 16'h70F1, 1'b1);
        wait_result("bp", 4);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            ci       = 1'($urandom);
            tick();
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp sum", 32'(sum), 32'(last_exp[15:0]));
            check("bp co", 32'(co), 32'(last_exp[16]));
        end
        in_valid = 1'b0;
        handshake("bp");
        tick();
        check("idle hold out_valid", 32'(out_valid), 32'd0);
        check("idle hold sum", 32'(sum), 32'(last_exp[15:0]));

        // Reset in the middle of RUN (idx = 2)
        accept("rst_mid", 16'hAAAA, 16'h5555, 1'b1);
        tick();
        tick();
        check("rst_mid state before", 32'(dbg_state), 32'(ST_RUN));
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        check("rst_mid sum", 32'(sum), 32'd0);
        check("rst_mid co", 32'(co), 32'd0);
        check("rst_mid out_valid", 32'(out_valid), 32'd0);
        check("rst_mid in_ready", 32'(in_ready), 32'd1);
        tick();
        check("rst_mid out_valid held", 32'(out_valid), 32'd0);
        rst = 1'b0;
        accept("after_rst", 16'h00FF, 16'h0001, 1'b0);
        wait_result("after_rst", 4);
        check("after_rst sum const", 32'(sum), 32'h0100);
        handshake("after_rst");

        // Back-to-back: in_valid and out_ready held high
        accepted  = 0;
        results   = 0;
        last_acc  = -1;
        cyc       = 0;
        out_ready = 1'b1;
        while (results < 100 && cyc < 1000) begin
            in_valid = (accepted < 100);
            if (in_ready === 1'b1 && accepted < 100) begin
                a  = 16'($urandom);
                b  = 16'($urandom);
                ci = 1'($urandom);
                exp_q.push_back(ref_sum(a, b, ci));
                if (last_acc >= 0) check("b2b interval", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                accepted++;
            end else begin
                a  = 16'($urandom);
                b  = 16'($urandom);
                ci = 1'($urandom);
            end
            if (out_valid === 1'b1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b sum", 32'(sum), 32'(e[15:0]));
                    check("b2b co", 32'(co), 32'(e[16]));
                end else begin
                    check("b2b unexpected result", 32'd1, 32'(exp_q.size()));
                end
                results++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b result count", 32'(results), 32'd100);
        check("b2b scoreboard drained", 32'(exp_q.size()), 32'd0);
        tick();
        check("b2b idle after", 32'(in_ready), 32'd1);

        // Single chunk: K = 1
        check("k1 in_ready", 32'(k1_in_ready), 32'd1);
        k1_a        = 8'hFF;
        k1_b        = 8'hFF;
        k1_ci       = 1'b1;
        k1_in_valid = 1'b1;
        tick();
        k1_in_valid = 1'b0;
        lat = 0;
        while (k1_out_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        check("k1 latency", 32'(lat), 32'd1);
        check("k1 sum", 32'(k1_sum), 32'hFF);
        check("k1 co", 32'(k1_co), 32'd1);
        k1_out_ready = 1'b1;
        tick();
        k1_out_ready = 1'b0;
        check("k1 idle after take", 32'(k1_in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter W, default 16, total operand width in bits; W SHALL be a multiple of N.
REQ-002 Parameter N, default 4, chunk width added per cycle; K = W/N chunks (K >= 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand set a, b, ci is valid.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  W  first operand, unsigned.
REQ-008 b  input  W  second operand, unsigned.
REQ-009 ci  input  1  carry in to chunk 0.
REQ-010 out_valid  output  1  sum and co are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  W  a + b + ci, modulo 2^W.
REQ-013 co  output  1  carry out of bit W-1.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE, with no others.
REQ-015 in_ready SHALL be 1 exactly in IDLE and 0 in RUN and DONE; out_valid SHALL be 1 exactly in DONE.
REQ-016 IDLE with in_valid=1 at an edge (acceptance): capture a, b, carry register <= ci, chunk index <= 0, go to RUN.
REQ-017 IDLE with in_valid=0: remain in IDLE; sum and co hold their last values.
REQ-018 In RUN, each edge SHALL compute the N-bit chunk idx from a[idx*N +: N] + b[idx*N +: N] + carry.
  - chunk result -> sum[idx*N +: N]
  - chunk carry -> carry register
  - idx increments by 1
REQ-019 RUN with idx = K-1: after that edge, go to DONE with co = final chunk carry.
REQ-020 Latency: out_valid SHALL rise exactly K edges after the acceptance edge (K=4 at defaults).
REQ-021 DONE with out_ready=0: sum, co and out_valid SHALL hold unchanged.
REQ-022 DONE with out_ready=1 at an edge: go to IDLE; sum and co keep their values; no new operand is accepted on that same edge.
REQ-023 Minimum initiation interval: K+2 cycles (accept, K RUN cycles, done handshake).
REQ-024 in_valid, a, b and ci SHALL be ignored outside IDLE; captured operands SHALL not change during RUN.
REQ-025 Arithmetic SHALL be unsigned with no saturation.
  - {co, sum} = a + b + ci, exact in W+1 bits
  - wrap-around appears only as co=1
REQ-026 K=1 SHALL be supported: RUN lasts one edge, then DONE.

Reset
REQ-027 While rst=1:
  - state = IDLE, idx = 0, carry = 0, sum = 0, co = 0
  - out_valid = 0, in_ready = 1
REQ-028 rst asserted in RUN or DONE SHALL discard the operation with no output handshake; the first acceptance is possible on the first edge after rst deasserts.

Structure
REQ-029 A shared package SHALL hold:
  - the FSM state enumeration
  - the defaults for W and N
  - the function computing K and idx width as max(1, clog2(K))
REQ-030 One sub-module SHALL do the per-chunk addition: the team's existing N-bit ripple-carry adder add.
  - one instance; chunk select done by muxing into it
  - carry-out taken from its s[N]
REQ-031 No combinational path SHALL exist from in_valid or out_ready to any output other than through the registered state.

Verification (W=16, N=4)
REQ-032 Wrap: a=0xFFFF, b=0x0001, ci=0 -> after 4 cycles out_valid=1, sum=0x0000, co=1.
REQ-033 Carry-in: a=0x1234, b=0x4321, ci=1 -> sum=0x5556, co=0; out_valid rises exactly 4 edges after acceptance.
REQ-034 Backpressure: out_ready held 0 for 3 cycles in DONE -> sum, co and out_valid=1 stable, in_ready=0; in_valid pulses are ignored.
REQ-035 Reset mid-op: rst pulsed at RUN idx=2 -> outputs 0, in_ready=1, no out_valid; next operand (0x00FF + 0x0001) -> sum=0x0100, co=0.
REQ-036 Back-to-back with in_valid=1 and out_ready=1 constantly, 100 random operands -> every result equals the W+1-bit reference sum, with initiation interval exactly 6 cycles.
REQ-037 W=8, N=8 (K=1): 0xFF + 0xFF + 1 -> sum=0xFF, co=1 one edge after acceptance.
